// File: rtl/erosion3x3.sv
// erosion3x3: 3x3 binary erosion of a streaming 1-bit mask, with de/hsync/vsync delayed to match.
// Define EROSION_CROSS_EN to erode with the 5-tap plus shape instead of the full 3x3 square.
module erosion3x3 #(
   parameter logic [9:0] H_SIZE = 10'd83
) (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic mask,
   input  logic in_de,
   input  logic in_hsync,
   input  logic in_vsync,
   output logic eroded,
   output logic out_de,
   output logic out_hsync,
   output logic out_vsync
);

   localparam int DEPTH = int'(H_SIZE);
   localparam int AW    = $clog2(DEPTH);
   localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

   // Structuring element, bit index = row*3 + col; row 0 = oldest line, col 0 = newest pixel.
`ifdef EROSION_CROSS_EN
   localparam logic [8:0] SE = 9'b010_111_010;
`else
   localparam logic [8:0] SE = 9'b111_111_111;
`endif

   typedef struct packed {
      logic de;
      logic mask;
   } px_t;

   px_t           s0_q;
   logic [1:0]    s0_sync_q;
   px_t           lb1_mem  [DEPTH];
   px_t           lb2_mem  [DEPTH];
   logic [1:0]    sync_mem [DEPTH];
   logic [AW-1:0] addr_q;
   logic [AW-1:0] addr_d;
   px_t           lb1_rd;
   px_t           lb2_rd;
   logic [1:0]    sync_rd;
   px_t           col0   [3];
   px_t           col1_q [3];
   px_t           col2_q [3];
   logic [1:0]    sync_win_q;
   logic          eroded_q;
   logic          eroded_d;
   logic          out_de_q;
   logic [1:0]    out_sync_q;

   // All three buffers share one wrapping address; reading before writing gives exactly H_SIZE delay.
   assign lb1_rd  = lb1_mem[addr_q];
   assign lb2_rd  = lb2_mem[addr_q];
   assign sync_rd = sync_mem[addr_q];
   assign addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;

   assign col0[0] = lb2_rd;
   assign col0[1] = lb1_rd;
   assign col0[2] = s0_q;

   // NOTE: every variable gets a value at the top of the block, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      px_t tap;
      tap      = '0;
      eroded_d = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            tap = (c == 0) ? col0[r] : ((c == 1) ? col1_q[r] : col2_q[r]);
            // Pixels outside the active image (de=0) are neutral and never erode their neighbours.
            if (SE[r*3 + c] && tap.de && !tap.mask) begin
               eroded_d = 1'b0;
            end
         end
      end
      if (!col1_q[1].de) begin
         eroded_d = 1'b0;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_q       <= '0;
         s0_sync_q  <= '0;
         addr_q     <= '0;
         sync_win_q <= '0;
         eroded_q   <= 1'b0;
         out_de_q   <= 1'b0;
         out_sync_q <= '0;
         // NOTE: line buffers are cleared too, so history from an interrupted frame cannot reach the next one.
         for (int i = 0; i < DEPTH; i++) begin
            lb1_mem[i]  <= '0;
            lb2_mem[i]  <= '0;
            sync_mem[i] <= '0;
         end
         for (int r = 0; r < 3; r++) begin
            col1_q[r] <= '0;
            col2_q[r] <= '0;
         end
      end else if (ce) begin
         s0_q             <= {in_de, mask};
         s0_sync_q        <= {in_vsync, in_hsync};
         lb1_mem[addr_q]  <= s0_q;
         lb2_mem[addr_q]  <= lb1_rd;
         sync_mem[addr_q] <= s0_sync_q;
         addr_q           <= addr_d;
         for (int r = 0; r < 3; r++) begin
            col1_q[r] <= col0[r];
            col2_q[r] <= col1_q[r];
         end
         sync_win_q <= sync_rd;
         eroded_q   <= eroded_d;
         out_de_q   <= col1_q[1].de;
         out_sync_q <= sync_win_q;
      end
   end

   assign eroded    = eroded_q;
   assign out_de    = out_de_q;
   assign out_hsync = out_sync_q[0];
   assign out_vsync = out_sync_q[1];

endmodule

// File: tb/tb_erosion3x3.sv
// Scoreboard bench for erosion3x3: a window-based reference model predicts each output 19 enabled cycles ahead.
module tb_erosion3x3;

   localparam logic [9:0] H = 10'd16;
   localparam int ACT_W   = 12;
   localparam int ACT_H   = 10;
   localparam int LINE    = 16;
   localparam int FRAME_L = 13;
   localparam int LAT     = 19;
`ifdef EROSION_CROSS_EN
   localparam int HOLE_ONES = 115;
`else
   localparam int HOLE_ONES = 111;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce = 1'b0;
   logic mask = 1'b0;
   logic in_de = 1'b0;
   logic in_hsync = 1'b0;
   logic in_vsync = 1'b0;
   logic eroded, out_de, out_hsync, out_vsync;

   erosion3x3 #(.H_SIZE(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .mask      (mask),
      .in_de     (in_de),
      .in_hsync  (in_hsync),
      .in_vsync  (in_vsync),
      .eroded    (eroded),
      .out_de    (out_de),
      .out_hsync (out_hsync),
      .out_vsync (out_vsync)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] v;
      int         fid;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   logic img [ACT_H][ACT_W];
   int   ones_cnt [8];
   int   act_cnt [8];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Erosion from the definition: AND of the structuring-element neighbours that lie inside the image.
   function automatic logic model_px(int r, int c);
      logic v;
      v = 1'b1;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
`ifdef EROSION_CROSS_EN
            if (dr != 0 && dc != 0) continue;
`endif
            if (r + dr >= 0 && r + dr < ACT_H && c + dc >= 0 && c + dc < ACT_W)
               v &= img[r + dr][c + dc];
         end
      end
      return v;
   endfunction

   // Present one pixel; with ce_rand, ce=0 cycles carry garbage inputs that the DUT must ignore.
   task automatic put(logic de, logic m, logic hs, logic vs, logic er, int fid, bit ce_rand);
      bit en;
      do begin
         @(negedge clk);
         rst = 1'b0;
         en  = ce_rand ? bit'($urandom_range(0, 1)) : 1'b1;
         ce  = en;
         if (en) begin
            in_de = de; mask = m; in_hsync = hs; in_vsync = vs;
            sb.push_back('{v: {er, de, hs, vs}, fid: fid});
         end else begin
            in_de = 1'($urandom); mask = 1'($urandom);
            in_hsync = 1'($urandom); in_vsync = 1'($urandom);
         end
      end while (!en);
   endtask

   task automatic send_line(int line, int fid, bit ce_rand);
      logic act;
      for (int col = 0; col < LINE; col++) begin
         act = (line < ACT_H) && (col < ACT_W);
         put(act, act ? img[line][col] : 1'($urandom), (col == 13 || col == 14), (line == 11),
             act ? model_px(line, col) : 1'b0, fid, ce_rand);
      end
   endtask

   task automatic send_frame(int fid, bit ce_rand, int abort_line);
      for (int line = 0; line < FRAME_L; line++) begin
         if (line == abort_line) return;
         send_line(line, fid, ce_rand);
      end
   endtask

   task automatic send_blank_lines(int n);
      for (int i = 0; i < n; i++) send_line(ACT_H + (i % 3), 0, 1'b0);
   endtask

   task automatic do_reset(int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b1;
         ce = 1'($urandom); in_de = 1'($urandom); mask = 1'($urandom);
         in_hsync = 1'($urandom); in_vsync = 1'($urandom);
      end
      sb.delete();
      for (int i = 0; i < LAT - 1; i++) sb.push_back('{v: 4'b0, fid: 0});
   endtask

   task automatic fill_img(int kind);
      for (int r = 0; r < ACT_H; r++)
         for (int c = 0; c < ACT_W; c++)
            case (kind)
               0:       img[r][c] = 1'b1;
               1:       img[r][c] = !(r == 5 && c == 6);
               2:       img[r][c] = (r == 3 && c == 3);
               default: img[r][c] = ($urandom_range(0, 3) != 0);
            endcase
   endtask

   // Monitor: pops one expectation per enabled edge; outputs must be zero in reset and frozen when ce=0.
   initial begin
      logic       rst_s, ce_s;
      logic [3:0] act, prev;
      exp_t       e;
      prev = '0;
      forever begin
         @(posedge clk);
         rst_s = rst;
         ce_s  = ce;
         #1;
         act = {eroded, out_de, out_hsync, out_vsync};
         if (rst_s) begin
            check("reset_out", act, 4'b0);
         end else if (ce_s) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow at %0t: got output %b with no expectation queued", $time, act);
            end else begin
               e = sb.pop_front();
               check("stream", act, e.v);
               if (e.fid > 0 && out_de) begin
                  act_cnt[e.fid]++;
                  if (eroded) ones_cnt[e.fid]++;
               end
            end
         end else begin
            check("ce_hold", act, prev);
         end
         prev = act;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 8; i++) begin
         ones_cnt[i] = 0;
         act_cnt[i]  = 0;
      end
      do_reset(40);
      for (int i = 0; i < 20; i++) put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      send_blank_lines(3);

      fill_img(0); send_frame(1, 1'b0, -1);
      fill_img(1); send_frame(2, 1'b0, -1);
      fill_img(2); send_frame(3, 1'b0, -1);
      fill_img(1); send_frame(4, 1'b1, -1);
      fill_img(3); send_frame(5, 1'b0, 5);
      do_reset(5);
      send_blank_lines(3);
      fill_img(3); send_frame(6, 1'b0, -1);
      send_blank_lines(2);
      @(posedge clk);
      #2;

      check("all_ones_active", act_cnt[1], 120);
      check("all_ones_eroded", ones_cnt[1], 120);
      check("hole_eroded", ones_cnt[2], HOLE_ONES);
      check("isolated_eroded", ones_cnt[3], 0);
      check("ce_rand_active", act_cnt[4], 120);
      check("ce_rand_eroded", ones_cnt[4], HOLE_ONES);
      check("random_frame_active", act_cnt[6], 120);
      check("sb_depth", sb.size(), LAT - 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
